// File: rtl/wb_msg_reader.sv
// Purpose: Wishbone pipelined initiator reading MSG_LEN bytes (addr 0..MSG_LEN-1) and handing each to a UART tx.
// Latency: i_start edge N -> o_cyc/o_stb in N+1; 3 cycles per byte unstalled, o_done 3*MSG_LEN cycles after start.
// Backpressure: i_stall holds REQ, i_tx_busy holds SEND; optional ack watchdog under macro WB_READER_TIMEOUT_EN.
module wb_msg_reader #(
    parameter int MSG_LEN = 12,
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    input  logic          i_stall,
    input  logic          i_ack,
    input  logic [DW-1:0] i_data,
    output logic          o_tx_stb,
    output logic [DW-1:0] o_tx_data,
    input  logic          i_tx_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);

    logic [1:0] state;

`ifdef WB_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;
`else
    // Watchdog limit has no meaning when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Read-only initiator.
    assign o_we = 1'b0;

    // Message sequencer: one single-beat read per byte, byte forwarded before the next request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_cyc     <= 1'b0;
            o_stb     <= 1'b0;
            o_addr    <= '0;
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
`ifdef WB_READER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state  <= S_REQ;
                        o_addr <= '0;
                        o_busy <= 1'b1;
                        o_cyc  <= 1'b1;
                        o_stb  <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Request is taken by the responder on the first unstalled edge.
                    if (!i_stall) begin
                        state <= S_WAIT;
                        o_stb <= 1'b0;
`ifdef WB_READER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (i_ack) begin
                        state     <= S_SEND;
                        o_cyc     <= 1'b0;
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= i_data;
`ifdef WB_READER_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Responder never answered: abandon the whole message.
                        state  <= S_IDLE;
                        o_cyc  <= 1'b0;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                        o_addr <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    if (!i_tx_busy) begin
                        o_tx_stb  <= 1'b0;
                        o_tx_data <= '0;
                        if (o_addr == LAST_ADDR) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            o_addr <= '0;
                        end else begin
                            state  <= S_REQ;
                            o_addr <= o_addr + 1'b1;
                            o_cyc  <= 1'b1;
                            o_stb  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_msg_reader.sv
// Scoreboard bench for wb_msg_reader: responder/transmitter models drive on negedge,
// expected bytes and addresses are queued at start and popped on each tx acceptance.
module tb_wb_msg_reader;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       o_busy, o_done, o_err, o_cyc, o_stb, o_we;
    logic [4:0] o_addr;
    logic       i_stall = 1'b0;
    logic       i_ack = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_tx_stb;
    logic [7:0] o_tx_data;
    logic       i_tx_busy = 1'b0;

    wb_msg_reader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr),
        .i_stall(i_stall), .i_ack(i_ack), .i_data(i_data),
        .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_lat = 36;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int nbytes = 0;
    int stall_addr = 99, stall_left = 0;
    int busy_left = 0;
    int noack_addr = 99, noack_entry = -1;
    int stb4_cnt = 0, hold0_cnt = 0;
    bit stray_ack = 0, hold_chk = 0;
    logic [7:0] mem [12];
    logic [7:0] sb_dat [$];
    int         sb_adr [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Responder, transmitter and output monitor, all on the falling edge.
    initial forever begin
        @(negedge i_clk);
        i_stall = o_stb && (int'(o_addr) == stall_addr) && (stall_left > 0);
        if (i_stall) stall_left--;
        i_ack  = (o_cyc && !o_stb && int'(o_addr) != noack_addr) || stray_ack;
        i_data = (o_addr < 5'd12) ? mem[o_addr] : 8'h00;
        i_tx_busy = o_tx_stb && (busy_left > 0);
        if (i_tx_busy) busy_left--;
        if (o_cyc && !o_stb && int'(o_addr) == noack_addr && noack_entry < 0) noack_entry = cyc;
        if (o_stb && o_addr == 5'd4) stb4_cnt++;
        if (o_tx_stb && o_addr == 5'd0) begin
            hold0_cnt++;
            if (hold_chk) check("hold_dat", o_tx_data, 8'h30);
        end
        if (o_tx_stb) check("no_req_during_tx", o_stb, 0);
        if (o_tx_stb && !i_tx_busy) begin
            nbytes++;
            if (sb_dat.size() == 0) check("sb_empty", sb_dat.size(), 1);
            else begin
                check("tx_dat", o_tx_data, sb_dat.pop_front());
                check("tx_addr", o_addr, sb_adr.pop_front());
            end
        end
        if (o_done) begin
            done_cnt++;
            check("done_lat", cyc - start_cyc, exp_lat);
            check("done_err_excl", o_err, 0);
        end
        if (o_err) begin
            err_cnt++;
            err_cyc = cyc;
            check("err_cyc_low", o_cyc, 0);
            check("err_busy_low", o_busy, 0);
        end
    end

    task automatic start_msg(input bit push);
        if (push)
            for (int i = 0; i < 12; i++) begin
                sb_dat.push_back(mem[i]);
                sb_adr.push_back(i);
            end
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        start_cyc = cyc;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge i_clk);
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check("rst_outs", {o_cyc, o_stb, o_we, o_addr, o_tx_stb, o_tx_data, o_busy, o_done, o_err}, 0);
        sb_dat.delete();
        sb_adr.delete();
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    initial begin
        int d0, n0, k;
        string s;
        s = "0xDEADBEEF";
        for (int i = 0; i < 10; i++) mem[i] = s[i];
        mem[10] = 8'h0A;
        mem[11] = 8'h0D;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("reset_outs", {o_cyc, o_stb, o_we, o_addr, o_tx_stb, o_tx_data, o_busy, o_done, o_err}, 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Plain message
        d0 = done_cnt; n0 = nbytes; exp_lat = 36;
        start_msg(1);
        check("busy_after_start", o_busy, 1);
        check("stb_after_start", o_stb, 1);
        wait_done(d0);
        check("nbytes_plain", nbytes - n0, 12);

        // Stall 3 cycles at address 4
        d0 = done_cnt; n0 = nbytes; exp_lat = 39;
        stall_addr = 4; stall_left = 3; stb4_cnt = 0;
        start_msg(1);
        wait_done(d0);
        check("stall_stb_cycles", stb4_cnt, 4);
        check("nbytes_stall", nbytes - n0, 12);
        stall_addr = 99;

        // Transmitter busy 5 cycles on the first byte
        d0 = done_cnt; n0 = nbytes; exp_lat = 41;
        busy_left = 5; hold0_cnt = 0; hold_chk = 1;
        start_msg(1);
        wait_done(d0);
        hold_chk = 0;
        check("tx_hold_cycles", hold0_cnt, 6);
        check("nbytes_busy", nbytes - n0, 12);

        // Reset in WAIT_ACK at address 6, then restart from address 0
        exp_lat = 36;
        start_msg(1);
        k = 0;
        while (!(o_cyc && !o_stb && o_addr == 5'd6) && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        check("reached_addr6", o_addr, 6);
        do_reset();
        d0 = done_cnt; n0 = nbytes;
        start_msg(1);
        wait_done(d0);
        check("nbytes_after_rst", nbytes - n0, 12);

        // Stray ack in IDLE and a second start mid-message are ignored
        stray_ack = 1;
        repeat (3) begin
            @(negedge i_clk);
            #1;
            check("stray_ack_cyc", o_cyc, 0);
            check("stray_ack_busy", o_busy, 0);
        end
        stray_ack = 0;
        @(negedge i_clk);
        d0 = done_cnt; n0 = nbytes;
        start_msg(1);
        repeat (10) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(d0);
        repeat (10) @(negedge i_clk);
        check("one_done", done_cnt - d0, 1);
        check("nbytes_ignore", nbytes - n0, 12);
        check("sb_drained", sb_dat.size(), 0);

        // Responder never acks address 2
        n0 = nbytes; noack_addr = 2; noack_entry = -1;
`ifdef WB_READER_TIMEOUT_EN
        d0 = err_cnt;
        start_msg(1);
        k = 0;
        while (err_cnt == d0 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check("err_seen", err_cnt - d0, 1);
        check("err_delay", err_cyc - noack_entry, 15);
        check("nbytes_timeout", nbytes - n0, 2);
        noack_addr = 99;
        sb_dat.delete();
        sb_adr.delete();
        d0 = done_cnt; n0 = nbytes;
        start_msg(1);
        wait_done(d0);
        check("nbytes_after_err", nbytes - n0, 12);
`else
        start_msg(1);
        repeat (60) @(negedge i_clk);
        #1;
        check("noack_busy", o_busy, 1);
        check("noack_cyc", o_cyc, 1);
        check("noack_err", err_cnt, 0);
        check("nbytes_noack", nbytes - n0, 2);
        noack_addr = 99;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
